// File: rtl/lzrw1_pkg.sv
// Shared types and constants for the LZRW1 decompressor history stage.
package lzrw1_pkg;

    localparam int unsigned LZ_MAX_COPY_LEN = 18;
    localparam int unsigned LZ_ENTRY_W      = 8;
    localparam int unsigned LZ_ADDR_W       = 12;
    localparam int unsigned LZ_LEN_W        = 5;

    typedef enum logic {
        HC_IDLE,
        HC_COPY
    } hc_state_t;

    typedef struct packed {
        logic                  is_copy;
        logic [LZ_ENTRY_W-1:0] literal;
        logic [LZ_ADDR_W-1:0]  offset;
        logic [LZ_LEN_W-1:0]   length;
    } lz_cmd_t;

endpackage

// File: rtl/history_ram.sv
// Circular history storage: one synchronous write port, one asynchronous read port, no reset.
module history_ram #(
    parameter int unsigned HISTORY_SIZE = 4096,
    parameter int unsigned ENTRY_WIDTH  = 8
) (
    input  logic                            clock,
    input  logic                            wr_en,
    input  logic [$clog2(HISTORY_SIZE)-1:0] wr_addr,
    input  logic [ENTRY_WIDTH-1:0]          wr_data,
    input  logic [$clog2(HISTORY_SIZE)-1:0] rd_addr,
    output logic [ENTRY_WIDTH-1:0]          rd_data
);

    logic [ENTRY_WIDTH-1:0] mem [HISTORY_SIZE];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/history_copy_engine.sv
// LZRW1 history stage: accepts literal/copy commands, expands copies one byte per cycle,
// emits the reconstructed stream and flags illegal copies.
module history_copy_engine
    import lzrw1_pkg::*;
#(
    parameter int unsigned HISTORY_SIZE = 4096,
    parameter int unsigned ENTRY_WIDTH  = 8,
    parameter int unsigned MAX_COPY_LEN = LZ_MAX_COPY_LEN,
    localparam int unsigned ADDR_W      = $clog2(HISTORY_SIZE),
    localparam int unsigned LEN_W       = $clog2(MAX_COPY_LEN + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_is_copy,
    input  logic [ENTRY_WIDTH-1:0] cmd_literal,
    input  logic [ADDR_W-1:0]      cmd_offset,
    input  logic [LEN_W-1:0]       cmd_length,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ENTRY_WIDTH-1:0] out_data,
    output logic                   busy,
    output logic [ADDR_W:0]        fill_count,
    output logic                   err,
    input  logic                   err_clear
);

    localparam logic [ADDR_W:0] FILL_MAX = (ADDR_W + 1)'(HISTORY_SIZE);

    hc_state_t              state, state_d;
    logic [ADDR_W-1:0]      wr_ptr, wr_ptr_d;
    logic [ADDR_W-1:0]      src_ptr, src_ptr_d;
    logic [LEN_W-1:0]       remaining, remaining_d;
    logic [ADDR_W:0]        fill_d;
    logic                   out_valid_d;
    logic [ENTRY_WIDTH-1:0] out_data_d;
    logic                   err_d;
    logic                   err_set;
    logic                   slot_free;
    logic                   accept;
    logic                   copy_legal;
    logic                   wr_en;
    logic [ENTRY_WIDTH-1:0] wr_data;
    logic [ENTRY_WIDTH-1:0] rd_data;

    history_ram #(
        .HISTORY_SIZE (HISTORY_SIZE),
        .ENTRY_WIDTH  (ENTRY_WIDTH)
    ) u_history_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (src_ptr),
        .rd_data (rd_data)
    );

    always_comb begin
        slot_free   = !out_valid || out_ready;
        cmd_ready   = (state == HC_IDLE) && slot_free;
        accept      = cmd_valid && cmd_ready;
        copy_legal  = (cmd_length != '0) && (cmd_length <= LEN_W'(MAX_COPY_LEN)) &&
                      (cmd_offset != '0) && ({1'b0, cmd_offset} <= fill_count);
        busy        = (state == HC_COPY);

        state_d     = state;
        wr_ptr_d    = wr_ptr;
        src_ptr_d   = src_ptr;
        remaining_d = remaining;
        fill_d      = fill_count;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        wr_en       = 1'b0;
        wr_data     = cmd_literal;
        err_set     = 1'b0;

        unique case (state)
            HC_IDLE: begin
                if (accept) begin
                    if (!cmd_is_copy) begin
                        wr_en = 1'b1;
                    end else if (copy_legal) begin
                        src_ptr_d   = wr_ptr - cmd_offset;
                        remaining_d = cmd_length;
                        state_d     = HC_COPY;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            HC_COPY: begin
                // offset >= 1 keeps src_ptr behind wr_ptr, so overlapping copies read settled bytes
                if (slot_free) begin
                    wr_en       = 1'b1;
                    wr_data     = rd_data;
                    src_ptr_d   = src_ptr + ADDR_W'(1);
                    remaining_d = remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) begin
                        state_d = HC_IDLE;
                    end
                end
            end
            default: state_d = HC_IDLE;
        endcase

        if (wr_en) begin
            wr_ptr_d    = wr_ptr + ADDR_W'(1);
            out_valid_d = 1'b1;
            out_data_d  = wr_data;
            if (fill_count != FILL_MAX) begin
                fill_d = fill_count + (ADDR_W + 1)'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        err_d = err_set ? 1'b1 : (err_clear ? 1'b0 : err);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= HC_IDLE;
            wr_ptr     <= '0;
            src_ptr    <= '0;
            remaining  <= '0;
            fill_count <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_d;
            wr_ptr     <= wr_ptr_d;
            src_ptr    <= src_ptr_d;
            remaining  <= remaining_d;
            fill_count <= fill_d;
            out_valid  <= out_valid_d;
            out_data   <= out_data_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_history_copy_engine.sv
// Scoreboard bench for history_copy_engine: a byte-history model predicts every output byte.
module tb_history_copy_engine;

    localparam int unsigned HS = 4096;
    localparam int unsigned AW = 12;
    localparam int unsigned LW = 5;
    localparam int unsigned ML = 18;

    logic          clock = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_is_copy;
    logic [7:0]    cmd_literal;
    logic [AW-1:0] cmd_offset;
    logic [LW-1:0] cmd_length;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic          busy;
    logic [AW:0]   fill_count;
    logic          err;
    logic          err_clear;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    logic [7:0]  q [$];
    logic [7:0]  hist [HS];
    int unsigned mwp   = 0;
    int unsigned mfill = 0;

    logic        stall_mode = 1'b0;
    int unsigned stall_cyc  = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data  = '0;

    history_copy_engine #(
        .HISTORY_SIZE (HS),
        .ENTRY_WIDTH  (8),
        .MAX_COPY_LEN (ML)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_is_copy (cmd_is_copy),
        .cmd_literal (cmd_literal),
        .cmd_offset  (cmd_offset),
        .cmd_length  (cmd_length),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .fill_count  (fill_count),
        .err         (err),
        .err_clear   (err_clear)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_write(input logic [7:0] b);
        hist[mwp] = b;
        q.push_back(b);
        mwp = (mwp + 1) % HS;
        if (mfill < HS) mfill++;
    endtask

    task automatic model_reset();
        q.delete();
        mwp   = 0;
        mfill = 0;
    endtask

    // Drive one command from posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_cmd(input logic is_copy, input logic [7:0] lit,
                            input int unsigned off, input int unsigned len);
        bit acc = 0;
        cmd_valid   = 1'b1;
        cmd_is_copy = is_copy;
        cmd_literal = lit;
        cmd_offset  = AW'(off);
        cmd_length  = LW'(len);
        for (int t = 0; t < 64; t++) begin
            @(negedge clock);
            if (cmd_ready) begin
                acc = 1;
                break;
            end
        end
        if (!acc) check_val("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        if (acc) begin
            if (!is_copy) begin
                model_write(lit);
            end else if (len >= 1 && len <= ML && off >= 1 && off <= mfill) begin
                for (int unsigned i = 0; i < len; i++) begin
                    model_write(hist[(mwp + HS - off) % HS]);
                end
            end
        end
    endtask

    task automatic send_lit(input logic [7:0] b);
        send_cmd(1'b0, b, 0, 0);
    endtask

    task automatic send_copy(input int unsigned off, input int unsigned len);
        send_cmd(1'b1, 8'h00, off, len);
    endtask

    task automatic drain();
        bit done = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clock);
            if (q.size() == 0 && !busy && !out_valid) begin
                done = 1;
                break;
            end
        end
        if (!done) check_val("drain_timeout", 32'(busy | out_valid | (q.size() != 0)), 32'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (stall_mode) begin
                out_ready = (stall_cyc % 4 == 0) || (stall_cyc % 4 == 3);
                stall_cyc++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Output monitor: pops the scoreboard on each handshake and checks stall stability.
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check_val("stall_valid", 32'(out_valid), 32'd1);
                    check_val("stall_data", 32'(out_data), 32'(prev_data));
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check_val("sb_nonempty", 32'(q.size()), 32'd1);
                    end else begin
                        exp_b = q.pop_front();
                        check_val("out_data", 32'(out_data), 32'(exp_b));
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned busy_cnt;
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_is_copy = 1'b0;
        cmd_literal = '0;
        cmd_offset  = '0;
        cmd_length  = '0;
        err_clear   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_data", 32'(out_data), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_fill", 32'(fill_count), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // 1: literals, one-cycle latency
        send_lit(8'h41);
        check_val("lat_valid_A", 32'(out_valid), 32'd1);
        check_val("lat_data_A", 32'(out_data), 32'h41);
        send_lit(8'h42);
        check_val("lat_data_B", 32'(out_data), 32'h42);
        send_lit(8'h43);
        check_val("lat_data_C", 32'(out_data), 32'h43);
        drain();
        check_val("fill_3", 32'(fill_count), 32'd3);

        // 2: overlapping copy of ABC
        send_copy(3, 6);
        check_val("copy_cmd_ready_low", 32'(cmd_ready), 32'd0);
        check_val("copy_busy", 32'(busy), 32'd1);
        drain();
        check_val("fill_9", 32'(fill_count), 32'd9);

        // 3: offset 1 run, busy exactly 18 cycles
        send_lit(8'h5A);
        send_copy(1, 18);
        busy_cnt = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clock);
            if (busy) busy_cnt++;
            else break;
        end
        check_val("busy_cycles", 32'(busy_cnt), 32'd18);
        @(posedge clock);
        #1;
        drain();
        check_val("fill_28", 32'(fill_count), 32'd28);

        // 4: back-pressure during copy
        send_lit(8'h78);
        send_lit(8'h79);
        stall_cyc  = 0;
        stall_mode = 1'b1;
        send_copy(2, 4);
        drain();
        stall_mode = 1'b0;
        check_val("fill_34", 32'(fill_count), 32'd34);

        // 5: pointer wrap and fill saturation
        for (int unsigned i = 0; i < HS + 5; i++) begin
            send_lit(8'((i * 7 + 3) & 32'hFF));
        end
        drain();
        check_val("fill_sat", 32'(fill_count), 32'(HS));
        send_copy(HS - 1, 3);
        drain();
        check_val("fill_sat_copy", 32'(fill_count), 32'(HS));

        // 6: illegal copies, err behaviour, reset mid-copy
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        send_lit(8'h11);
        send_lit(8'h22);
        drain();
        send_copy(3, 4);
        repeat (3) @(posedge clock);
        #1;
        check_val("illegal_err", 32'(err), 32'd1);
        check_val("illegal_no_out", 32'(out_valid), 32'd0);
        check_val("illegal_busy", 32'(busy), 32'd0);
        check_val("illegal_fill", 32'(fill_count), 32'd2);
        repeat (5) @(posedge clock);
        #1;
        check_val("err_held", 32'(err), 32'd1);
        err_clear = 1'b1;
        @(posedge clock);
        #1;
        err_clear = 1'b0;
        check_val("err_cleared", 32'(err), 32'd0);
        err_clear = 1'b1;
        send_copy(0, 3);
        err_clear = 1'b0;
        check_val("err_set_wins", 32'(err), 32'd1);
        err_clear = 1'b1;
        @(posedge clock);
        #1;
        err_clear = 1'b0;
        check_val("err_cleared2", 32'(err), 32'd0);
        send_copy(1, 0);
        check_val("err_len0", 32'(err), 32'd1);
        send_copy(1, ML + 1);
        check_val("err_len_big_no_busy", 32'(busy), 32'd0);

        send_copy(1, 10);
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_val("midrst_out_valid", 32'(out_valid), 32'd0);
        check_val("midrst_busy", 32'(busy), 32'd0);
        check_val("midrst_fill", 32'(fill_count), 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_val("post_rst_valid", 32'(out_valid), 32'd0);
        check_val("post_rst_busy", 32'(busy), 32'd0);

        check_val("sb_left", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
